bldc_hall_emulator: RTL and testbench



---
 rtl/bldc_hall_pkg.sv | 44 ++++
 rtl/bldc_step_timer.sv | 31 +++
 rtl/bldc_hall_emulator.sv | 129 ++++++++++++
 tb/tb_bldc_hall_emulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bldc_hall_pkg.sv
// Shared hall-code definitions for the BLDC hall emulator and hall counter.
// Holds the six valid codes, the sequencer state encoding and the index-stepping helpers.
package bldc_hall_pkg;

    localparam logic [2:0] HALL_STEP_1 = 3'b101;
    localparam logic [2:0] HALL_STEP_2 = 3'b100;
    localparam logic [2:0] HALL_STEP_3 = 3'b110;
    localparam logic [2:0] HALL_STEP_4 = 3'b010;
    localparam logic [2:0] HALL_STEP_5 = 3'b011;
    localparam logic [2:0] HALL_STEP_6 = 3'b001;
    localparam logic [2:0] HALL_INVALID = 3'b000;
    localparam logic [2:0] IDX_LAST = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } emu_state_t;

    function automatic logic [2:0] hall_code(input logic [2:0] index);
        logic [2:0] code;
        case (index)
            3'd0:    code = HALL_STEP_1;
            3'd1:    code = HALL_STEP_2;
            3'd2:    code = HALL_STEP_3;
            3'd3:    code = HALL_STEP_4;
            3'd4:    code = HALL_STEP_5;
            3'd5:    code = HALL_STEP_6;
            default: code = HALL_STEP_1;
        endcase
        return code;
    endfunction

    // dir = 1 walks the table upward; both directions wrap within 0..5.
    function automatic logic [2:0] next_index(input logic [2:0] index, input logic dir);
        logic [2:0] nxt;
        if (dir) begin
            nxt = (index >= IDX_LAST) ? 3'd0 : index + 3'd1;
        end else begin
            nxt = (index == 3'd0) ? IDX_LAST : index - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bldc_step_timer.sv
// Loadable down-counter that flags expiry when it sits at zero while enabled.
// Intended for reuse by commutation and PWM sequencers.
module bldc_step_timer #(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [PERIOD_WIDTH-1:0] i_load_value,
    input  logic                    i_enable,
    output logic                    o_expire,
    output logic [PERIOD_WIDTH-1:0] o_count
);

    logic [PERIOD_WIDTH-1:0] r_count;

    assign o_expire = i_enable && (r_count == '0);
    assign o_count  = r_count;

    // Load has priority so an expiry can reload in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/bldc_hall_emulator.sv
// Emits bursts of 6-step BLDC hall codes, one transition per commanded period.
// Optional HALL_EMU_FAULT_EN adds fault_inject, which forces hall to 000 without disturbing the sequencer.
module bldc_hall_emulator
    import bldc_hall_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int STEPS_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [STEPS_WIDTH-1:0]  cmd_steps,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
`ifdef HALL_EMU_FAULT_EN
    input  logic                    fault_inject,
`endif
    output logic [2:0]              hall,
    output logic [2:0]              step_index,
    output logic                    busy,
    output logic                    done
);

    emu_state_t              r_state;
    logic                    r_dir;
    logic [PERIOD_WIDTH-1:0] r_period_m1;
    logic [STEPS_WIDTH-1:0]  r_remaining;
    logic [2:0]              r_step_index;
    logic [2:0]              r_hall;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_run;
    logic                    w_step;
    logic                    w_timer_load;
    logic [PERIOD_WIDTH-1:0] w_cmd_period_m1;
    logic [PERIOD_WIDTH-1:0] w_timer_value;
    logic [PERIOD_WIDTH-1:0] w_timer_count;
    logic [2:0]              w_index_next;
    logic                    w_fault;

    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_run     = (r_state == ST_RUN);

    // A zero period behaves as one clock per step, so reload value saturates at 0.
    assign w_cmd_period_m1 = (cmd_period == '0) ? '0 : cmd_period - 1'b1;
    assign w_timer_load    = (w_accept && (cmd_steps != '0)) || w_step;
    assign w_timer_value   = w_accept ? w_cmd_period_m1 : r_period_m1;

`ifdef HALL_EMU_FAULT_EN
    assign w_fault = fault_inject;
`else
    assign w_fault = 1'b0;
`endif

    // Abort gates the timer enable, so a coinciding expiry never emits its step.
    bldc_step_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_step_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .i_enable     (w_run && !abort),
        .o_expire     (w_step),
        .o_count      (w_timer_count)
    );

    assign w_index_next = w_step ? next_index(r_step_index, r_dir) : r_step_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= 1'b0;
            r_period_m1  <= '0;
            r_remaining  <= '0;
            r_step_index <= 3'd0;
            r_hall       <= HALL_STEP_1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_step_index <= w_index_next;
            r_hall       <= w_fault ? HALL_INVALID : hall_code(w_index_next);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dir       <= cmd_dir;
                        r_period_m1 <= w_cmd_period_m1;
                        r_remaining <= cmd_steps;
                        if (cmd_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_step) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == STEPS_WIDTH'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hall       = r_hall;
    assign step_index = r_step_index;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bldc_hall_emulator.sv
// Self-checking bench for bldc_hall_emulator: directed test-plan bursts followed by random traffic,
// compared each cycle against an elapsed-time model of the burst schedule.
module tb_bldc_hall_emulator;

    localparam int PW = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          abort = 1'b0;
    logic          fault_inject = 1'b0;
    logic          cmd_ready;
    logic [2:0]    hall;
    logic [2:0]    step_index;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    bldc_hall_emulator #(
        .PERIOD_WIDTH (PW),
        .STEPS_WIDTH  (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_steps    (cmd_steps),
        .cmd_period   (cmd_period),
        .abort        (abort),
`ifdef HALL_EMU_FAULT_EN
        .fault_inject (fault_inject),
`endif
        .hall         (hall),
        .step_index   (step_index),
        .busy         (busy),
        .done         (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: position of a burst is base +/- floor(elapsed / P), capped at N steps.
    int  hall_tab [6] = '{5, 4, 6, 2, 3, 1};
    bit  m_active = 0;
    bit  m_done = 0;
    int  m_e0, m_n, m_p, m_dir, m_base;
    int  m_idx = 0;
    int  edge_n = 0;

    function automatic int pos(input int base, input int dir, input int k);
        if (dir != 0) return (base + k) % 6;
        return (base - (k % 6) + 6) % 6;
    endfunction

    task automatic tick();
        int k;
        @(posedge clk);
        edge_n++;
        #1;
        if (reset) begin
            m_active = 0;
            m_idx    = 0;
            m_done   = 0;
        end else if (m_active) begin
            m_done = 0;
            k = edge_n - m_e0;
            if (abort) begin
                m_active = 0;
            end else if (k >= m_n * m_p) begin
                m_idx    = pos(m_base, m_dir, m_n);
                m_active = 0;
                m_done   = 1;
            end else begin
                m_idx = pos(m_base, m_dir, k / m_p);
            end
        end else begin
            m_done = 0;
            if (cmd_valid) begin
                m_dir = cmd_dir;
                m_n   = cmd_steps;
                m_p   = (cmd_period == 0) ? 1 : cmd_period;
                if (m_n == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_e0     = edge_n;
                    m_base   = m_idx;
                end
            end
        end
        check("step_index", step_index, m_idx);
        check("hall", hall, hall_tab[m_idx]);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("cmd_ready", cmd_ready, (!m_active && !reset));
    endtask

    task automatic send(input logic dir, input int steps, input int period);
        cmd_dir    = dir;
        cmd_steps  = SW'(steps);
        cmd_period = PW'(period);
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int accept_edge;
        int done_edge;
        int changes;
        logic [2:0] prev_hall;

        do_reset();
        repeat (10) tick();
        check("idle_hall", hall, 3'b101);
        check("idle_index", step_index, 0);

        // Forward 7 steps, period 4.
        send(1'b1, 7, 4);
        accept_edge = edge_n;
        done_edge   = -1;
        changes     = 0;
        prev_hall   = hall;
        for (int i = 0; i < 40 && done_edge < 0; i++) begin
            tick();
            if (hall != prev_hall) changes++;
            prev_hall = hall;
            if (done) done_edge = edge_n;
        end
        check("fwd_done_latency", done_edge - accept_edge, 28);
        check("fwd_changes", changes, 7);
        check("fwd_final_index", step_index, 1);
        check("fwd_final_hall", hall, 3'b100);
        repeat (3) tick();

        // Reverse 2 steps, period 1, from index 0.
        do_reset();
        send(1'b0, 2, 1);
        tick();
        check("rev_first_hall", hall, 3'b001);
        tick();
        check("rev_second_hall", hall, 3'b011);
        check("rev_second_done", done, 1'b1);
        check("rev_final_index", step_index, 4);
        repeat (2) tick();

        // Zero steps, then zero period.
        send(1'b1, 0, 5);
        check("zero_steps_done", done, 1'b1);
        check("zero_steps_busy", busy, 1'b0);
        tick();
        send(1'b1, 3, 0);
        repeat (4) tick();
        check("zero_period_index", step_index, 1);

        // Abort on the second expiry with cmd_valid held through RUN.
        repeat (2) tick();
        cmd_dir    = 1'b1;
        cmd_steps  = SW'(10);
        cmd_period = PW'(3);
        cmd_valid  = 1'b1;
        tick();
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("abort_index", step_index, 2);
        check("abort_busy", busy, 1'b0);
        check("abort_no_done", done, 1'b0);
        repeat (3) tick();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_dir    = 1'($urandom_range(0, 1));
            cmd_steps  = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom_range(1, 9));
            cmd_period = PW'($urandom_range(0, 4));
            abort      = ($urandom_range(0, 24) == 0);
            tick();
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (60) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
